// File: rtl/chord_song_pkg.sv
// chord_song_pkg: ROM word layout, FSM states and helpers shared by the song reader.
// Optional build macro: SONG_LOOP_EN (repeat the song instead of stopping).
package chord_song_pkg;

    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int WORD_W   = 1 + NOTE_W + DUR_W;
    localparam int DUR_LSB  = 0;
    localparam int NOTE_LSB = DUR_LSB + DUR_W;
    localparam int ADV_BIT  = NOTE_LSB + NOTE_W;

    localparam logic [NOTE_W+DUR_W-1:0] END_MARKER = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_ISSUE,
        S_HOLDOFF,
        S_WAIT_BEATS,
        S_DONE
    } state_t;

    function automatic logic [WORD_W-1:0] rom_word(
        input logic              adv,
        input logic [NOTE_W-1:0] note,
        input logic [DUR_W-1:0]  dur
    );
        return {adv, note, dur};
    endfunction

    // The advance bit of an end marker carries no meaning.
    function automatic logic is_end_marker(input logic [WORD_W-1:0] w);
        return w[ADV_BIT-1:0] == END_MARKER;
    endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: synchronous-read song table, address {song, index}, 1-cycle latency.
// Song content lives here only, so it can be replaced without touching the reader FSM.
module song_rom
    import chord_song_pkg::*;
#(
    parameter  int NUM_SONGS        = 4,
    parameter  int ENTRIES_PER_SONG = 32,
    localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int IDX_W  = $clog2(ENTRIES_PER_SONG),
    localparam int ADDR_W = SONG_W + IDX_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data
);

    logic [SONG_W-1:0] sel;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;

    assign sel = addr[ADDR_W-1:IDX_W];
    assign idx = addr[IDX_W-1:0];

    always_comb begin
        word = rom_word(1'b0, '0, '0);
        case (sel)
            SONG_W'(0): begin
                case (idx)
                    IDX_W'(0): word = rom_word(1'b0, 6'd10, 6'd4);
                    IDX_W'(1): word = rom_word(1'b0, 6'd14, 6'd4);
                    IDX_W'(2): word = rom_word(1'b1, 6'd17, 6'd4);
                    default:   word = rom_word(1'b0, '0, '0);
                endcase
            end
            SONG_W'(1): begin
                case (idx)
                    IDX_W'(0): word = rom_word(1'b1, 6'd20, 6'd0);
                    IDX_W'(1): word = rom_word(1'b1, 6'd25, 6'd1);
                    default:   word = rom_word(1'b0, '0, '0);
                endcase
            end
            // Full-length song with no end marker: note = index + 1.
            SONG_W'(2): begin
                word = rom_word(1'b0, NOTE_W'(idx) + 1'b1, DUR_W'(1));
            end
            default: begin
                case (idx)
                    IDX_W'(0): word = rom_word(1'b1, 6'd40, 6'd2);
                    IDX_W'(1): word = rom_word(1'b1, 6'd45, 6'd2);
                    default:   word = rom_word(1'b0, '0, '0);
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        data <= word;
    end

endmodule

// File: rtl/chord_song_reader.sv
// chord_song_reader: walks a song ROM and hands note/duration pairs to the chord player.
// Build macro SONG_LOOP_EN: restart the song at index 0 instead of stopping in DONE.
module chord_song_reader
    import chord_song_pkg::*;
#(
    parameter  int NUM_SONGS        = 4,
    parameter  int ENTRIES_PER_SONG = 32,
    parameter  int HOLDOFF          = 2,
    localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int IDX_W  = $clog2(ENTRIES_PER_SONG),
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              beat,
    input  logic              player_ready,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              song_done
);

    state_t state_q, state_d;

    logic [SONG_W-1:0]       song_q;
    logic [IDX_W-1:0]        index_q;
    logic                    adv_q;
    logic [NOTE_W-1:0]       note_q;
    logic [DUR_W-1:0]        dur_q;
    logic [HOLD_W-1:0]       hold_q;
    logic [DUR_W-1:0]        beat_q;
    logic                    done_q;
    logic [SONG_W+IDX_W-1:0] rom_addr;
    logic [WORD_W-1:0]       rom_data;

    logic latch_song;
    logic load_word;
    logic issue;
    logic hold_inc;
    logic load_beats;
    logic dec_beat;
    logic next_entry;
    logic inc_index;
    logic clr_index;
    logic finish;
    logic done_set;
    logic hold_last;
    logic index_last;

    assign rom_addr   = {song_q, index_q};
    assign hold_last  = (hold_q == HOLD_W'(HOLDOFF - 1));
    assign index_last = (index_q == IDX_W'(ENTRIES_PER_SONG - 1));

    song_rom #(
        .NUM_SONGS        (NUM_SONGS),
        .ENTRIES_PER_SONG (ENTRIES_PER_SONG)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        latch_song = 1'b0;
        load_word  = 1'b0;
        issue      = 1'b0;
        hold_inc   = 1'b0;
        load_beats = 1'b0;
        dec_beat   = 1'b0;
        next_entry = 1'b0;
        inc_index  = 1'b0;
        clr_index  = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (play) begin
                    latch_song = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                if (is_end_marker(rom_data)) begin
                    finish = 1'b1;
                end else begin
                    load_word = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (player_ready && play) begin
                    issue   = 1'b1;
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (play) begin
                    if (!hold_last) begin
                        hold_inc = 1'b1;
                    end else if (adv_q) begin
                        load_beats = 1'b1;
                        state_d    = S_WAIT_BEATS;
                    end else begin
                        next_entry = 1'b1;
                    end
                end
            end
            S_WAIT_BEATS: begin
                if (play) begin
                    if (beat_q == '0) begin
                        next_entry = 1'b1;
                    end else if (beat) begin
                        dec_beat = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stepping past the last entry ends the song like an end marker.
        if (next_entry) begin
            if (index_last) begin
                finish = 1'b1;
            end else begin
                inc_index = 1'b1;
                state_d   = S_FETCH;
            end
        end

        if (finish) begin
`ifdef SONG_LOOP_EN
            clr_index = 1'b1;
            state_d   = S_FETCH;
`else
            state_d   = S_DONE;
`endif
        end

`ifdef SONG_LOOP_EN
        done_set = finish;
`else
        done_set = (state_d == S_DONE);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            song_q  <= '0;
            index_q <= '0;
            adv_q   <= 1'b0;
            note_q  <= '0;
            dur_q   <= '0;
            hold_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            if (latch_song) begin
                song_q <= song;
            end
            if (clr_index) begin
                index_q <= '0;
            end else if (inc_index) begin
                index_q <= index_q + 1'b1;
            end
            if (load_word) begin
                adv_q  <= rom_data[ADV_BIT];
                note_q <= rom_data[NOTE_LSB +: NOTE_W];
                dur_q  <= rom_data[DUR_LSB +: DUR_W];
            end
            if (issue) begin
                hold_q <= '0;
            end else if (hold_inc) begin
                hold_q <= hold_q + 1'b1;
            end
            if (load_beats) begin
                beat_q <= dur_q;
            end else if (dec_beat) begin
                beat_q <= beat_q - 1'b1;
            end
            done_q <= done_set;
        end
    end

    // The load strobe is combinational so the chord stage sees it in the
    // same cycle player_ready is granted.
    assign new_note  = issue;
    assign note      = note_q;
    assign duration  = dur_q;
    assign song_done = done_q;

endmodule

// File: tb/tb_chord_song_reader.sv
// tb_chord_song_reader: scoreboard bench for the song reader.
// Expected note/duration pairs are queued per scenario and popped on each new_note.
`timescale 1ns/1ps
module tb_chord_song_reader;

    localparam int HOLDOFF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       play = 1'b0;
    logic [1:0] song = 2'd0;
    logic       beat = 1'b0;
    logic       player_ready = 1'b0;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pulse = -1;
    int done_hi = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_w;

    always #5 clk = ~clk;

    chord_song_reader dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .song         (song),
        .beat         (beat),
        .player_ready (player_ready),
        .note         (note),
        .duration     (duration),
        .new_note     (new_note),
        .song_done    (song_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && song_done) done_hi++;
        if (reset && new_note) begin
            checks++;
            if (play !== 1'b1) begin
                failures++;
                $display("FAIL pulse_while_paused: new_note=1 with play=%0b, required play=1", play);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: note=%0d dur=%0d, required no pulse", note, duration);
            end else begin
                exp_w = exp_q.pop_front();
                if ({note, duration} !== exp_w) begin
                    failures++;
                    $display("FAIL pulse_data: note=%0d dur=%0d, required note=%0d dur=%0d",
                             note, duration, exp_w[11:6], exp_w[5:0]);
                end
            end
            if (last_pulse >= 0) begin
                checks++;
                if (cyc - last_pulse < HOLDOFF + 3) begin
                    failures++;
                    $display("FAIL pulse_spacing: gap=%0d cycles, required >=%0d",
                             cyc - last_pulse, HOLDOFF + 3);
                end
            end
            last_pulse = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        play = 1'b0;
        beat = 1'b0;
        player_ready = 1'b0;
        exp_q.delete();
        last_pulse = -1;
        repeat (2) tick();
        reset = 1'b1;
        done_hi = 0;
        tick();
    endtask

    task automatic give_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: pending pulses=%0d after %0d cycles, required 0", name, exp_q.size(), budget);
        end
    endtask

    task automatic check_done(input string name, input logic want);
        checks++;
        if ((done_hi > 0) !== want) begin
            failures++;
            $display("FAIL %s: song_done seen=%0b, required %0b", name, done_hi > 0, want);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({note, duration, new_note, song_done} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state: note=%0d dur=%0d new_note=%0b done=%0b, required all 0",
                     note, duration, new_note, song_done);
        end
        do_reset();
        song = 2'd0;
        play = 1'b1;
        repeat (6) tick();
        checks++;
        if (note !== 6'd10) begin
            failures++;
            $display("FAIL issue_note: note=%0d, required 10", note);
        end
        reset = 1'b0;
        player_ready = 1'b1;
        #1;
        checks++;
        if ({new_note, song_done, note} !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid_issue: new_note=%0b done=%0b note=%0d, required 0 0 0",
                     new_note, song_done, note);
        end
        play = 1'b0;
        exp_q.delete();
        last_pulse = -1;
        repeat (2) tick();
        exp_q.push_back({6'd10, 6'd4});
        reset = 1'b1;
        play = 1'b1;
        wait_drain(20, "first_after_reset");
        player_ready = 1'b0;
    endtask

    task automatic test_chord_triad();
        do_reset();
        exp_q.push_back({6'd10, 6'd4});
        exp_q.push_back({6'd14, 6'd4});
        exp_q.push_back({6'd17, 6'd4});
        song = 2'd0;
        play = 1'b1;
        player_ready = 1'b1;
        wait_drain(60, "triad");
        player_ready = 1'b0;
        repeat (3) tick();
        repeat (3) give_beat();
        repeat (8) tick();
        check_done("triad_wait_3_beats", 1'b0);
`ifdef SONG_LOOP_EN
        exp_q.push_back({6'd10, 6'd4});
        player_ready = 1'b1;
        give_beat();
        wait_drain(20, "loop_reissue");
        player_ready = 1'b0;
        checks++;
        if (done_hi !== 1) begin
            failures++;
            $display("FAIL loop_done_pulse: high cycles=%0d, required 1", done_hi);
        end
`else
        give_beat();
        repeat (6) tick();
        check_done("end_marker_done", 1'b1);
        player_ready = 1'b1;
        repeat (4) give_beat();
        play = 1'b0;
        repeat (3) tick();
        checks++;
        if (song_done !== 1'b1) begin
            failures++;
            $display("FAIL done_held: song_done=%0b, required 1", song_done);
        end
        player_ready = 1'b0;
`endif
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        song = 2'd0;
        play = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (note !== 6'd10 || new_note !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold: bad cycles=%0d, required 0", bad);
        end
        exp_q.push_back({6'd10, 6'd4});
        player_ready = 1'b1;
        #1;
        checks++;
        if (new_note !== 1'b1) begin
            failures++;
            $display("FAIL ready_grant: new_note=%0b, required 1", new_note);
        end
        wait_drain(5, "backpressure_pulse");
        player_ready = 1'b0;
    endtask

    task automatic test_pause();
        do_reset();
        exp_q.push_back({6'd10, 6'd4});
        exp_q.push_back({6'd14, 6'd4});
        exp_q.push_back({6'd17, 6'd4});
        song = 2'd0;
        play = 1'b1;
        player_ready = 1'b1;
        wait_drain(60, "pause_triad");
        player_ready = 1'b0;
        repeat (3) tick();
        repeat (2) give_beat();
        play = 1'b0;
        repeat (5) give_beat();
        play = 1'b1;
        tick();
        give_beat();
        repeat (8) tick();
        check_done("pause_one_more_beat", 1'b0);
        give_beat();
        repeat (6) tick();
        check_done("pause_second_beat", 1'b1);
    endtask

    task automatic test_zero_duration();
        do_reset();
        exp_q.push_back({6'd20, 6'd0});
        exp_q.push_back({6'd25, 6'd1});
        song = 2'd1;
        play = 1'b1;
        player_ready = 1'b1;
        wait_drain(40, "zero_dur_no_beat");
        player_ready = 1'b0;
        repeat (10) tick();
        check_done("zero_dur_waits_beat", 1'b0);
        give_beat();
        repeat (6) tick();
        check_done("zero_dur_end", 1'b1);
    endtask

    task automatic test_index_wrap();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back({6'(i + 1), 6'd1});
        end
`ifdef SONG_LOOP_EN
        exp_q.push_back({6'd1, 6'd1});
`endif
        song = 2'd2;
        play = 1'b1;
        player_ready = 1'b1;
        wait_drain(400, "wrap_pulses");
        player_ready = 1'b0;
        repeat (6) tick();
        check_done("wrap_done", 1'b1);
`ifndef SONG_LOOP_EN
        checks++;
        if (song_done !== 1'b1) begin
            failures++;
            $display("FAIL wrap_done_level: song_done=%0b, required 1", song_done);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_chord_triad();
        test_backpressure();
        test_pause();
        test_zero_duration();
        test_index_wrap();
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chord_song_reader.md
Name: chord_song_reader

Overview:
- Upstream sequencer for the three-voice chord player: steps through a song ROM and issues note/duration pairs with a one-cycle new_note pulse whenever the chord stage reports a free voice.
- Entries with advance=0 belong to the same chord and are issued back-to-back.
- An entry with advance=1 closes the chord; the reader then waits that entry's duration in beats before fetching further.
- Sits between the top-level play/song controls and the chord player.

Parameters:
- NUM_SONGS, 4, number of songs in ROM; song select width is clog2(NUM_SONGS).
- ENTRIES_PER_SONG, 32, ROM words per song; entry index width is clog2(ENTRIES_PER_SONG).
- HOLDOFF, 2, cycles after a new_note pulse during which player_ready is ignored; covers the chord stage's registered load path.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play  in  1  level; 1 = advance song, 0 = freeze in place
- song  in  2  song select; sampled only in IDLE
- beat  in  1  one-cycle beat strobe
- player_ready  in  1  chord stage has at least one free voice
- note  out  6  note code to load
- duration  out  6  duration in beats
- new_note  out  1  one-cycle load strobe
- song_done  out  1  level; song finished

Behaviour:
- Reset (asynchronous, reset=0):
  - State=IDLE, index=0, beat counter=0.
  - Outputs: note=0, duration=0, new_note=0, song_done=0.
- ROM word, 13 bits: [12] advance, [11:6] note, [5:0] duration.
  - End marker = note 0 with duration 0; its advance bit is ignored.
- ROM read is synchronous, 1-cycle latency. Address = {song_latched, index}.
- IDLE:
  - On play=1: latch song, go FETCH.
  - Changing song requires reset.
- FETCH: drive address, go WAIT_ROM.
- WAIT_ROM: register the ROM word.
  - End marker -> DONE.
  - Otherwise -> ISSUE.
- ISSUE:
  - Holds note/duration on outputs.
  - When player_ready=1 and play=1: pulse new_note for exactly one cycle, go HOLDOFF.
  - note/duration stay stable through the pulse and until the next ISSUE.
- HOLDOFF:
  - Count HOLDOFF cycles, ignoring player_ready.
  - Then, if advance=1 -> WAIT_BEATS with beat counter = duration.
  - Otherwise increment index -> FETCH.
- WAIT_BEATS:
  - Decrement on each beat while play=1.
  - At 0: increment index -> FETCH.
  - duration=0 with advance=1 leaves WAIT_BEATS on the next cycle with no beat needed.
- Index wrap: incrementing from ENTRIES_PER_SONG-1 goes to DONE; the index never silently wraps.
- DONE:
  - song_done=1, new_note=0. Stays until reset.
  - play is ignored.
- play=0 mid-song:
  - Freezes ISSUE, WAIT_BEATS and HOLDOFF counting.
  - FETCH/WAIT_ROM still complete, so the ROM data is not lost.
  - No new_note while play=0.
- Simultaneous events:
  - A beat arriving in the same cycle WAIT_BEATS is entered is not counted.
  - A beat coinciding with play falling is not counted.
- Reset mid-operation aborts immediately; any in-flight new_note is dropped.

Optional Feature:
- Macro: SONG_LOOP_EN.
- Defined:
  - End marker or index wrap sets index=0 and goes to FETCH (repeat song).
  - song_done pulses for one cycle per loop instead of holding.
- Undefined: behaviour exactly as above (terminal DONE).

Decomposition:
- Package chord_song_pkg holds:
  - NOTE_W=6, DUR_W=6
  - the ROM word field offsets
  - END_MARKER constant
  - state enum: IDLE, FETCH, WAIT_ROM, ISSUE, HOLDOFF, WAIT_BEATS, DONE
- Sub-module song_rom: synchronous-read ROM, address in, 13-bit word out. Kept separate so song content can be swapped without touching the FSM.

Test Plan:
- Reset/idle:
  - Stimulus: reset=0 mid-ISSUE.
  - Required: new_note=0 and song_done=0 immediately, note=0; after release and play=1, the first new_note carries entry 0.
- Chord triad:
  - Stimulus: entries {0,10,4},{0,14,4},{1,17,4}, player_ready=1 throughout.
  - Required: three new_note pulses with notes 10, 14, 17, each separated by ≥HOLDOFF+3 cycles; then no fetch until 4 beats counted.
- Backpressure:
  - Stimulus: player_ready=0 for 20 cycles in ISSUE.
  - Required: no pulse; note stays stable; the pulse appears on the first cycle player_ready=1.
- Pause:
  - Stimulus: play=0 during WAIT_BEATS after 2 of 4 beats, 5 beats skipped, then play=1.
  - Required: exactly 2 more beats needed before the next fetch.
- End and wrap:
  - End marker at index 3 -> song_done=1 held, with no further new_note.
  - A song with no marker -> DONE after index 31.
  - With SONG_LOOP_EN -> entry 0 reissued and a one-cycle song_done pulse.
- Zero-duration advance:
  - Stimulus: entry {1,20,0}.
  - Required: the next entry's new_note follows with no beat required.
